ram_arbiter: RTL

- Shares the single-port byte-lane data RAM between the instruction-fetch port (ifu) and the load/store port (lsu).
- The RAM has a combinational read and a posedge write. This block grants one master per cycle and drives the RAM interface combinationally from the winner.
- Read data is registered and returned one cycle after the grant.
- Arbitration is fixed-priority lsu > ifu, with a starvation counter that guarantees ifu progress.

---
 rtl/ram_arbiter_if.sv | 65 ++++++
 rtl/ram_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
//
// Bundles the two requester ports (instruction fetch "ifu", load/store "lsu")
// and the single-port data RAM port that ram_arbiter sits between.
//
// Modports:
//   slave  - the arbiter's view: requests and RAM read data come in, grants,
//            responses and the RAM drive go out.
//   master - the environment's view (requesters + RAM model): the reverse.
//
// Signal summary:
//   ifu_req/ifu_addr                      fetch request (read only)
//   ifu_gnt/ifu_rvalid/ifu_rdata/ifu_err  fetch grant and response
//   lsu_req/lsu_wr_en/lsu_addr/lsu_sel/lsu_wr_data   load/store request
//   lsu_gnt/lsu_rvalid/lsu_rdata/lsu_err  load/store grant and response
//   ram_ce/ram_wr_en/ram_addr/ram_addr_sel/ram_wr_data   RAM drive
//   ram_data_in                           RAM combinational read data
// -----------------------------------------------------------------------------
interface ram_arbiter_if;
   // instruction fetch port
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_gnt;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic        ifu_err;

   // load/store port
   logic        lsu_req;
   logic        lsu_wr_en;
   logic [31:0] lsu_addr;
   logic [3:0]  lsu_sel;
   logic [31:0] lsu_wr_data;
   logic        lsu_gnt;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        lsu_err;

   // data RAM port
   logic        ram_ce;
   logic        ram_wr_en;
   logic [31:0] ram_addr;
   logic [3:0]  ram_addr_sel;
   logic [31:0] ram_wr_data;
   logic [31:0] ram_data_in;

   modport slave (
      input  ifu_req, ifu_addr,
      output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
      input  lsu_req, lsu_wr_en, lsu_addr, lsu_sel, lsu_wr_data,
      output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
      output ram_ce, ram_wr_en, ram_addr, ram_addr_sel, ram_wr_data,
      input  ram_data_in
   );

   modport master (
      output ifu_req, ifu_addr,
      input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
      output lsu_req, lsu_wr_en, lsu_addr, lsu_sel, lsu_wr_data,
      input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
      input  ram_ce, ram_wr_en, ram_addr, ram_addr_sel, ram_wr_data,
      output ram_data_in
   );
endinterface : ram_arbiter_if

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port, byte-lane data RAM between the instruction-fetch
// port (ifu) and the load/store port (lsu). At most one master is granted per
// cycle; the RAM is driven combinationally from the winner, so a grant in
// cycle N performs the RAM access in cycle N (read sampled / write committed
// on the closing edge) and the winner sees rvalid for exactly cycle N+1.
//
// Arbitration: fixed priority lsu > ifu. A saturating starvation counter
// counts consecutive lsu wins while ifu is waiting; once it reaches
// STARVE_LIMIT, ifu takes the next contended grant and the counter clears.
//
// Parameters:
//   STARVE_LIMIT  consecutive contended lsu grants before ifu is forced (1..15)
//   RAM_BYTES     RAM address window in bytes (only used by the range check)
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ram_arbiter_if.slave - requester ports and RAM port
//
// Optional feature (macro RAM_ARB_RANGE_CHK_EN):
//   When defined, a granted access with addr >= RAM_BYTES is still granted
//   and still answered at N+1, but ram_ce is held low for it (no write
//   reaches the RAM) and the response carries rdata=0, err=1.
//   When undefined, ifu_err and lsu_err are tied low.
// -----------------------------------------------------------------------------
module ram_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned RAM_BYTES    = 16384
) (
   input  logic          clk,
   input  logic          rst_n,
   ram_arbiter_if.slave  bus
);

   // Response routing: which master owned the RAM in the previous cycle.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RESP_I = 2'd1,
      RESP_D = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   // Parameter sanity, caught at elaboration.
   if ((STARVE_LIMIT == 0) || (STARVE_LIMIT > 15)) begin : g_bad_limit
      $error("ram_arbiter: STARVE_LIMIT must lie in 1..15");
   end
   if (RAM_BYTES == 0) begin : g_bad_bytes
      $error("ram_arbiter: RAM_BYTES must be non-zero");
   end

   state_t      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        ifu_win, lsu_win;
   logic        ifu_oob, lsu_oob;
   logic [31:0] ifu_rdata_q, lsu_rdata_q;

   // ---------------------------------------------------------------------------
   // Address range check
   // ---------------------------------------------------------------------------
`ifdef RAM_ARB_RANGE_CHK_EN
   assign ifu_oob = (bus.ifu_addr >= RAM_BYTES);
   assign lsu_oob = (bus.lsu_addr >= RAM_BYTES);
`else
   assign ifu_oob = 1'b0;
   assign lsu_oob = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Arbitration, starvation counter, FSM next state and RAM drive
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      ifu_win          = 1'b0;
      lsu_win          = 1'b0;
      starve_d         = starve_q;
      state_d          = IDLE;
      bus.ifu_gnt      = 1'b0;
      bus.lsu_gnt      = 1'b0;
      bus.ram_ce       = 1'b0;
      bus.ram_wr_en    = 1'b0;
      bus.ram_addr     = '0;
      bus.ram_addr_sel = '0;
      bus.ram_wr_data  = '0;

      // lsu wins unless ifu is also waiting and has been passed over
      // STARVE_LIMIT times in a row.
      if (bus.lsu_req && !(bus.ifu_req && (starve_q == LIMIT))) begin
         lsu_win = 1'b1;
      end else if (bus.ifu_req) begin
         ifu_win = 1'b1;
      end

      // The counter only tracks an uninterrupted run of contended lsu wins;
      // any cycle where ifu is idle or served restarts it.
      if (ifu_win || !bus.ifu_req) begin
         starve_d = '0;
      end else if (lsu_win && (starve_q != LIMIT)) begin
         starve_d = starve_q + 4'd1;
      end

      if (ifu_win) begin
         state_d          = RESP_I;
         bus.ifu_gnt      = 1'b1;
         bus.ram_ce       = !ifu_oob;
         bus.ram_wr_en    = 1'b0;
         bus.ram_addr     = bus.ifu_addr;
         bus.ram_addr_sel = 4'b1111;
         bus.ram_wr_data  = '0;
      end else if (lsu_win) begin
         state_d          = RESP_D;
         bus.lsu_gnt      = 1'b1;
         // An out-of-range access never enables the RAM, so a store to it is
         // dropped even though wr_en is passed through.
         bus.ram_ce       = !lsu_oob;
         bus.ram_wr_en    = bus.lsu_wr_en;
         bus.ram_addr     = bus.lsu_addr;
         bus.ram_addr_sel = bus.lsu_sel;
         bus.ram_wr_data  = bus.lsu_wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // State, counter and response data registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         ifu_rdata_q <= '0;
         lsu_rdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples the
         // pre-edge values of the others, whatever the statement order.
         state_q  <= state_d;
         starve_q <= starve_d;
         // rdata only moves for the winner; the loser keeps its last value.
         if (ifu_win) begin
            ifu_rdata_q <= ifu_oob ? 32'h0 : bus.ram_data_in;
         end
         if (lsu_win) begin
            lsu_rdata_q <= (lsu_oob || bus.lsu_wr_en) ? 32'h0 : bus.ram_data_in;
         end
      end
   end

   // rvalid comes straight from the registered owner state: one cycle after
   // the grant, exactly one cycle long, and dropped immediately by reset.
   assign bus.ifu_rvalid = (state_q == RESP_I);
   assign bus.lsu_rvalid = (state_q == RESP_D);
   assign bus.ifu_rdata  = ifu_rdata_q;
   assign bus.lsu_rdata  = lsu_rdata_q;

   // ---------------------------------------------------------------------------
   // Range error flags
   // ---------------------------------------------------------------------------
`ifdef RAM_ARB_RANGE_CHK_EN
   logic ifu_err_q, lsu_err_q;

   // Reloaded every cycle so the flag is only ever high alongside rvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifu_err_q <= 1'b0;
         lsu_err_q <= 1'b0;
      end else begin
         ifu_err_q <= ifu_win && ifu_oob;
         lsu_err_q <= lsu_win && lsu_oob;
      end
   end

   assign bus.ifu_err = ifu_err_q;
   assign bus.lsu_err = lsu_err_q;
`else
   assign bus.ifu_err = 1'b0;
   assign bus.lsu_err = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Structural invariants
   // ---------------------------------------------------------------------------
   a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.ifu_gnt && bus.lsu_gnt));

   a_counter_bound : assert property (@(posedge clk) disable iff (!rst_n)
      starve_q <= LIMIT);

   a_one_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.ifu_rvalid && bus.lsu_rvalid));

endmodule : ram_arbiter
